// File: rtl/vga_pattern_if.sv
// Pixel-side bundle between vga_controller, vga_pattern_gen and vga_color_extend.
// The master is the timing source; the slave is the pattern generator.
interface vga_pattern_if;
  logic [9:0]  vga_x;
  logic [9:0]  vga_y;
  logic        vga_vs;
  logic        mode_next;
  logic [15:0] vga_data;
  logic [1:0]  mode;
  logic [15:0] frame_count;

  modport master (
    output vga_x, vga_y, vga_vs, mode_next,
    input  vga_data, mode, frame_count
  );

  modport slave (
    input  vga_x, vga_y, vga_vs, mode_next,
    output vga_data, mode, frame_count
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Frame-synchronous VGA test-pattern source: solid, colour bars, checkerboard, bouncing boxes.
// Mode changes and box motion are applied only on the VS falling edge.
//
//   state        | meaning
//   MODE_SOLID   | whole active area is 16'h380F
//   MODE_BARS    | eight vertical colour bars
//   MODE_CHECKER | 32x32 black/white checkerboard
//   MODE_BOXES   | N_BOXES bouncing boxes over a 16'h380F background
module vga_pattern_gen #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int N_BOXES  = 2,
  parameter int BOX_SIZE = 16,
  parameter int STEP     = 2
) (
  input  logic         clk,
  input  logic         reset,
  vga_pattern_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_SOLID   = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_BOXES   = 2'd3
  } mode_e;

  localparam logic signed [11:0] LIM_X  = 12'(H_RES - BOX_SIZE);
  localparam logic signed [11:0] LIM_Y  = 12'(V_RES - BOX_SIZE);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] BOX_S  = 12'(BOX_SIZE);
  localparam logic [15:0] BG_COLOUR = 16'h380F;
  localparam logic [15:0] TBL [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                      16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  mode_e       mode_q, mode_d;
  logic        vs_d_q, btn_d_q;
  logic        pending_q, pending_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] pix_q, pix_d;
  logic        frame_tick, btn_edge;

  logic signed [11:0] bx_q  [N_BOXES];
  logic signed [11:0] by_q  [N_BOXES];
  logic signed [11:0] bdx_q [N_BOXES];
  logic signed [11:0] bdy_q [N_BOXES];
  logic signed [11:0] bx_d  [N_BOXES];
  logic signed [11:0] by_d  [N_BOXES];
  logic signed [11:0] bdx_d [N_BOXES];
  logic signed [11:0] bdy_d [N_BOXES];

  // One axis of bounce: returns {position, velocity} after one frame.
  function automatic logic [23:0] axis_step(input logic signed [11:0] p,
                                            input logic signed [11:0] d,
                                            input logic signed [11:0] lim);
    logic signed [11:0] n;
    n = p + d;
    if (n > lim)           return {lim, -STEP_S};
    else if (n < 12'sd0)   return {12'sd0, STEP_S};
    else                   return {n, d};
  endfunction

  assign frame_tick = vs_d_q & ~bus.vga_vs;
  assign btn_edge   = bus.mode_next & ~btn_d_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q    <= MODE_SOLID;
      vs_d_q    <= 1'b1;
      btn_d_q   <= 1'b1;
      pending_q <= 1'b0;
      fc_q      <= 16'h0000;
      pix_q     <= 16'h0000;
      for (int i = 0; i < N_BOXES; i++) begin
        bx_q[i]  <= 12'(2 * i * BOX_SIZE);
        by_q[i]  <= 12'(i * BOX_SIZE);
        bdx_q[i] <= STEP_S;
        bdy_q[i] <= (i % 2 == 0) ? STEP_S : -STEP_S;
      end
    end else begin
      mode_q    <= mode_d;
      vs_d_q    <= bus.vga_vs;
      btn_d_q   <= bus.mode_next;
      pending_q <= pending_d;
      fc_q      <= fc_d;
      pix_q     <= pix_d;
      for (int i = 0; i < N_BOXES; i++) begin
        bx_q[i]  <= bx_d[i];
        by_q[i]  <= by_d[i];
        bdx_q[i] <= bdx_d[i];
        bdy_q[i] <= bdy_d[i];
      end
    end
  end

  // Requests collapse: any number of edges in a frame advance the mode once.
  always_comb begin
    mode_d    = mode_q;
    pending_d = pending_q | btn_edge;
    fc_d      = fc_q;
    if (frame_tick) begin
      fc_d = fc_q + 16'd1;
      if (pending_q | btn_edge) begin
        mode_d    = mode_e'(mode_q + 2'd1);
        pending_d = 1'b0;
      end
    end
  end

  // Motion uses the pre-tick mode, so the tick that enters BOXES does not move them.
  always_comb begin
    for (int i = 0; i < N_BOXES; i++) begin
      bx_d[i]  = bx_q[i];
      by_d[i]  = by_q[i];
      bdx_d[i] = bdx_q[i];
      bdy_d[i] = bdy_q[i];
      if (frame_tick && mode_q == MODE_BOXES) begin
        {bx_d[i], bdx_d[i]} = axis_step(bx_q[i], bdx_q[i], LIM_X);
        {by_d[i], bdy_d[i]} = axis_step(by_q[i], bdy_q[i], LIM_Y);
      end
    end
  end

  logic signed [11:0] px, py;
  assign px = {2'b00, bus.vga_x};
  assign py = {2'b00, bus.vga_y};

  always_comb begin
    pix_d = 16'h0000;
    if ({1'b0, bus.vga_x} < 11'(H_RES) && {1'b0, bus.vga_y} < 11'(V_RES)) begin
      case (mode_q)
        MODE_SOLID:   pix_d = BG_COLOUR;
        MODE_BARS:    pix_d = TBL[3'(bus.vga_x / 10'(H_RES / 8))];
        MODE_CHECKER: pix_d = (bus.vga_x[5] ^ bus.vga_y[5]) ? 16'hFFFF : 16'h0000;
        MODE_BOXES: begin
          pix_d = BG_COLOUR;
          // Scan high to low so the lowest-index hit box has the last word.
          for (int i = N_BOXES - 1; i >= 0; i--) begin
            if (px >= bx_q[i] && px < bx_q[i] + BOX_S &&
                py >= by_q[i] && py < by_q[i] + BOX_S)
              pix_d = TBL[3'((i + 1) % 8)];
          end
        end
        default:      pix_d = 16'h0000;
      endcase
    end
  end

  assign bus.vga_data    = pix_q;
  assign bus.mode        = mode_q;
  assign bus.frame_count = fc_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: random pixel probes against a frame-level model.
module tb_vga_pattern_gen;
  localparam int H = 640, V = 480, NB = 2, BS = 16, ST = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_pattern_if bus ();
  vga_pattern_gen #(.H_RES(H), .V_RES(V), .N_BOXES(NB), .BOX_SIZE(BS), .STEP(ST))
    dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  // Frame-level model state
  int m_mode, m_fc, m_ticks;
  bit m_pend;
  int bx [NB], by [NB], dx [NB], dy [NB];
  logic [15:0] tbl [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_fc = 0; m_pend = 0; m_ticks = 0;
    for (int i = 0; i < NB; i++) begin
      bx[i] = 2 * i * BS; by[i] = i * BS;
      dx[i] = ST;         dy[i] = (i % 2 == 0) ? ST : -ST;
    end
  endtask

  function automatic void bounce(inout int p, inout int d, input int lim);
    int n = p + d;
    if (n > lim)    begin p = lim; d = -ST; end
    else if (n < 0) begin p = 0;   d = ST;  end
    else            p = n;
  endfunction

  task automatic model_tick(input bit edge_now);
    if (m_mode == 3) begin
      for (int i = 0; i < NB; i++) begin
        bounce(bx[i], dx[i], H - BS);
        bounce(by[i], dy[i], V - BS);
      end
      m_ticks++;
    end
    if (m_pend || edge_now) begin
      m_mode = (m_mode + 1) % 4;
      m_pend = 0;
    end
    m_fc = (m_fc + 1) % 65536;
  endtask

  function automatic logic [15:0] ref_pix(input int x, input int y);
    if (x >= H || y >= V) return 16'h0000;
    case (m_mode)
      0: return 16'h380F;
      1: return tbl[x / (H / 8)];
      2: return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      default: begin
        for (int i = 0; i < NB; i++)
          if (x >= bx[i] && x < bx[i] + BS && y >= by[i] && y < by[i] + BS)
            return tbl[(i + 1) % 8];
        return 16'h380F;
      end
    endcase
  endfunction

  task automatic pix_check(input int x, input int y);
    @(negedge clk);
    bus.vga_x = 10'(x);
    bus.vga_y = 10'(y);
    @(posedge clk);
    #1;
    check_val($sformatf("pix(%0d,%0d) mode%0d", x, y, m_mode), bus.vga_data, ref_pix(x, y));
  endtask

  task automatic rand_pix(input int n);
    for (int k = 0; k < n; k++)
      pix_check($urandom_range(0, 700), $urandom_range(0, 520));
  endtask

  task automatic pulse();
    @(negedge clk); bus.mode_next = 1'b1;
    @(negedge clk); bus.mode_next = 1'b0;
    m_pend = 1;
  endtask

  task automatic do_tick(input bit with_edge);
    @(negedge clk);
    bus.vga_vs = 1'b0;
    if (with_edge) bus.mode_next = 1'b1;
    @(negedge clk);
    bus.vga_vs    = 1'b1;
    bus.mode_next = 1'b0;
    model_tick(with_edge);
    check_val("mode after tick", bus.mode, m_mode);
    check_val("frame_count after tick", bus.frame_count, m_fc);
  endtask

  task automatic box_probe();
    for (int i = 0; i < NB; i++) begin
      pix_check(bx[i], by[i]);
      pix_check(bx[i] + BS - 1, by[i] + BS - 1);
      pix_check(bx[i] + BS, by[i]);
      if (bx[i] > 0) pix_check(bx[i] - 1, by[i]);
      if (by[i] > 0) pix_check(bx[i], by[i] - 1);
    end
  endtask

  initial begin
    tbl = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    reset = 1'b1;
    bus.vga_vs = 1'b1; bus.mode_next = 1'b0; bus.vga_x = '0; bus.vga_y = '0;
    model_reset();
    #12;
    check_val("reset mode", bus.mode, 0);
    check_val("reset frame_count", bus.frame_count, 0);
    check_val("reset vga_data", bus.vga_data, 0);
    @(negedge clk); reset = 1'b0;

    // solid, then a mid-frame request honoured only at the tick
    pix_check(5, 5);
    check_val("mode idle", bus.mode, 0);
    check_val("frame_count idle", bus.frame_count, 0);
    rand_pix(8);
    pulse();
    repeat (5) @(negedge clk);
    check_val("mode held mid-frame", bus.mode, 0);
    do_tick(0);
    pix_check(100, 10);
    rand_pix(16);

    // several edges in one frame plus one on the tick: exactly one step
    repeat (3) pulse();
    do_tick(1);
    rand_pix(16);
    do_tick(0);
    do_tick(1);

    // boxes: first tick in BOXES moves them
    rand_pix(8);
    do_tick(0);
    pix_check(2, 2);
    pix_check(1, 1);
    pix_check(700, 10);
    for (int t = 2; t <= 320; t++) begin
      do_tick(0);
      if (t == 8 || t == 9 || t == 10 || t == 231 || t == 232 || t == 233 ||
          t == 312 || t == 313 || t == 314)
        box_probe();
      if (t % 40 == 0) rand_pix(4);
    end

    // async reset mid-frame
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async reset mode", bus.mode, 0);
    check_val("async reset frame_count", bus.frame_count, 0);
    check_val("async reset vga_data", bus.vga_data, 0);
    @(negedge clk); reset = 1'b0;
    model_reset();
    repeat (3) do_tick(1);
    box_probe();
    rand_pix(8);

    // frame_count wrap
    @(negedge clk);
    force dut.fc_q = 16'hFFFF;
    #1 release dut.fc_q;
    m_fc = 65535;
    @(negedge clk);
    check_val("frame_count preset", bus.frame_count, 16'hFFFF);
    do_tick(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
